// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - CP0 Status/Cause/EPC and interrupt entry/return sequencer
module interrupt_controller #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
    parameter int          NUM_IRQ      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irq_in,
    input  logic                 boundary,
    input  logic [31:0]          pc_next,
    input  logic                 eret,
    input  logic                 mtc0_we,
    input  logic [4:0]           cp0_addr,
    input  logic [31:0]          mtc0_data,
    output logic [31:0]          mfc0_data,
    output logic [31:0]          cause_out,
    output logic [31:0]          epc_out,
    output logic                 flush,
    output logic                 pc_load,
    output logic [31:0]          pc_target,
    output logic [NUM_IRQ-1:0]   irq_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_VECTOR,
        S_HANDLER,
        S_RETURN
    } state_t;

    localparam logic [31:0] IRQ_FIELD   = ((32'd1 << NUM_IRQ) - 32'd1) << 10;
    localparam logic [31:0] STATUS_MASK = IRQ_FIELD | 32'h0000_0003;

    state_t               state_q, state_d;
    logic [31:0]          status_q, status_d;
    logic [31:0]          cause_q, cause_d;
    logic [31:0]          epc_q, epc_d;
    logic [NUM_IRQ-1:0]   line_q, line_d;

    logic [NUM_IRQ-1:0]   pending;
    logic [NUM_IRQ-1:0]   winner;
    logic                 take;

    assign pending = status_q[10 +: NUM_IRQ] & cause_q[10 +: NUM_IRQ];
    assign take    = (state_q == S_IDLE) && status_q[0] && !status_q[1]
                     && (|pending) && boundary;

    // Descending scan so the lowest-index pending line is the last one kept.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                winner    = '0;
                winner[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        epc_d    = epc_q;
        line_d   = line_q;
        cause_d  = '0;
        cause_d[10 +: NUM_IRQ] = irq_in;

        if (mtc0_we && cp0_addr == 5'd12) status_d = mtc0_data & STATUS_MASK;
        if (mtc0_we && cp0_addr == 5'd14) epc_d = mtc0_data;

        // Hardware updates are applied last so they override a same-edge mtc0.
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    state_d     = S_FLUSH;
                    epc_d       = pc_next;
                    status_d[1] = 1'b1;
                    line_d      = winner;
                end
            end
            S_FLUSH:   state_d = S_VECTOR;
            S_VECTOR:  state_d = S_HANDLER;
            S_HANDLER: if (eret) state_d = S_RETURN;
            S_RETURN: begin
                state_d     = S_IDLE;
                status_d[1] = 1'b0;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            status_q <= '0;
            cause_q  <= '0;
            epc_q    <= '0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            line_q   <= line_d;
        end
    end

    always_comb begin
        case (cp0_addr)
            5'd12:   mfc0_data = status_q;
            5'd13:   mfc0_data = cause_q;
            5'd14:   mfc0_data = epc_q;
            default: mfc0_data = '0;
        endcase
    end

    assign cause_out = cause_q;
    assign epc_out   = epc_q;
    assign flush     = (state_q == S_FLUSH);
    assign pc_load   = (state_q == S_VECTOR) || (state_q == S_RETURN);
    assign irq_ack   = (state_q == S_VECTOR) ? line_q : '0;

    always_comb begin
        case (state_q)
            S_VECTOR: pc_target = HANDLER_ADDR;
            S_RETURN: pc_target = epc_q;
            default:  pc_target = '0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - scoreboard bench for interrupt_controller
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  irq_in = '0;
    logic        boundary = 1'b0;
    logic [31:0] pc_next = '0;
    logic        eret = 1'b0;
    logic        mtc0_we = 1'b0;
    logic [4:0]  cp0_addr = '0;
    logic [31:0] mtc0_data = '0;
    logic [31:0] mfc0_data, cause_out, epc_out, pc_target;
    logic        flush, pc_load;
    logic [5:0]  irq_ack;

    interrupt_controller dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .boundary(boundary),
        .pc_next(pc_next), .eret(eret), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr),
        .mtc0_data(mtc0_data), .mfc0_data(mfc0_data), .cause_out(cause_out),
        .epc_out(epc_out), .flush(flush), .pc_load(pc_load), .pc_target(pc_target),
        .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fl;
        logic        ld;
        logic [31:0] tgt;
        logic [5:0]  ack;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    always @(negedge clk) begin
        if (!rst && (flush || pc_load)) begin
            ev_t got, e;
            got = '{fl: flush, ld: pc_load, tgt: pc_target, ack: irq_ack};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe got=%h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL strobe_event got=%h required=%h", got, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] req);
        cp0_addr = a;
        #1;
        chk(name, mfc0_data, req);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1'b1; cp0_addr = a; mtc0_data = d;
        tick(1);
        mtc0_we = 1'b0;
    endtask

    task automatic push_entry(input logic [5:0] ack);
        exp_q.push_back('{fl: 1'b1, ld: 1'b0, tgt: 32'h0, ack: 6'h0});
        exp_q.push_back('{fl: 1'b0, ld: 1'b1, tgt: 32'h80, ack: ack});
    endtask

    task automatic do_return(input logic [31:0] epc);
        exp_q.push_back('{fl: 1'b0, ld: 1'b1, tgt: epc, ack: 6'h0});
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
        tick(3);
    endtask

    task automatic chk_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s got=%0d pending events required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset asserted asynchronously away from a clock edge.
        #3 rst = 1'b1;
        #1;
        rd("rst_status", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        chk("rst_strobes", {31'h0, flush}, 32'h0);
        chk("rst_pc_load", {31'h0, pc_load}, 32'h0);
        chk("rst_target", pc_target, 32'h0);
        chk("rst_ack", {26'h0, irq_ack}, 32'h0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // Basic entry and exit.
        wr(5'd12, 32'h0000_0401);
        rd("status_wr", 5'd12, 32'h0000_0401);
        rd("other_addr", 5'd5, 32'h0);
        push_entry(6'b000001);
        irq_in = 6'b000001; pc_next = 32'h0000_1234; boundary = 1'b1;
        tick(6);
        chk_drained("basic_entry_seen");
        rd("basic_epc", 5'd14, 32'h0000_1234);
        rd("basic_exl", 5'd12, 32'h0000_0403);
        irq_in = '0; boundary = 1'b0;
        tick(2);
        do_return(32'h0000_1234);
        chk_drained("basic_return_seen");
        rd("basic_exl_clr", 5'd12, 32'h0000_0401);

        // Masking: IM off, IE off, no boundary.
        irq_in = 6'b000001; boundary = 1'b1;
        wr(5'd12, 32'h0000_0001);
        tick(20);
        rd("mask_cause", 5'd13, 32'h0000_0400);
        wr(5'd12, 32'h0000_0400);
        tick(20);
        boundary = 1'b0;
        wr(5'd12, 32'h0000_0401);
        tick(20);
        chk("mask_cause_out", cause_out, 32'h0000_0400);
        irq_in = '0;
        tick(2);
        boundary = 1'b1;

        // Priority with all lines enabled.
        wr(5'd12, 32'h0000_FC01);
        push_entry(6'b000100);
        irq_in = 6'b101100; pc_next = 32'h0000_2000;
        tick(6);
        chk_drained("prio_entry_seen");
        // No nesting, even after software clears EXL in the handler.
        wr(5'd12, 32'h0000_FC01);
        tick(20);
        rd("prio_epc", 5'd14, 32'h0000_2000);
        irq_in = '0;
        tick(2);
        do_return(32'h0000_2000);
        chk_drained("prio_return_seen");

        // Stray eret in IDLE.
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
        tick(5);

        // Write conflict: mtc0 EPC lands on the take edge.
        wr(5'd12, 32'h0000_0401);
        push_entry(6'b000001);
        pc_next = 32'h0000_3000;
        irq_in = 6'b000001;
        tick(1);
        wr(5'd14, 32'hDEAD_BEEF);
        tick(4);
        chk_drained("conflict_entry_seen");
        chk("conflict_epc", epc_out, 32'h0000_3000);
        wr(5'd13, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h0000_0400);
        irq_in = '0;
        tick(2);
        do_return(32'h0000_3000);
        chk_drained("conflict_return_seen");
        rd("conflict_exl_clr", 5'd12, 32'h0000_0401);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Coprocessor-0 interrupt sequencer for the single-cycle/pipelined MIPS core. It owns Status (reg 12), Cause (reg 13) and EPC (reg 14), samples external interrupt lines, and decides when to take an interrupt. On entry it flushes the pipeline, saves the return PC and redirects fetch to the handler; on `eret` it restores the PC. The Cause/EPC outputs feed the CP0 read mux selected by `mfc0` register number 13/14.

## Interface
- `HANDLER_ADDR`, default 32'h0000_0080: fetch target on interrupt entry.
- `NUM_IRQ`, default 6: number of external interrupt lines, 1..6; unused IP/IM bits read 0.

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `irq_in`  in  NUM_IRQ  level-sensitive external interrupt requests.
- `boundary`  in  1  core is at an instruction boundary and may be interrupted this cycle.
- `pc_next`  in  32  PC of the next instruction to execute; saved to EPC on entry.
- `eret`  in  1  decoded `eret` instruction retiring this cycle.
- `mtc0_we`  in  1  CP0 write strobe.
- `cp0_addr`  in  5  CP0 register number for `mtc0`/`mfc0`.
- `mtc0_data`  in  32  CP0 write data.
- `mfc0_data`  out  32  combinational read of register `cp0_addr`.
- `cause_out`  out  32  Cause register (read mux input 13).
- `epc_out`  out  32  EPC register (read mux input 14).
- `flush`  out  1  squash in-flight instructions.
- `pc_load`  out  1  force PC to `pc_target` at next edge.
- `pc_target`  out  32  redirect address; 0 when `pc_load` low.
- `irq_ack`  out  NUM_IRQ  one-hot pulse naming the line being serviced.

## Operation
- Status: bit0 IE, bit1 EXL, bits[10+NUM_IRQ-1:10] IM; all other bits read 0. Fully software-writable via `mtc0` to 12.
- Cause: bits[10+NUM_IRQ-1:10] IP = `irq_in` registered each cycle (one-cycle sample). ExcCode [6:2] = 0 (interrupt). Read-only; `mtc0` to 13 ignored.
- EPC: writable via `mtc0` to 14; written by hardware on entry.
- `mfc0_data`: reg 12/13/14 contents; any other address returns 0.
- Take condition (evaluated combinationally in IDLE): IE=1, EXL=0, (IP & IM) != 0, `boundary`=1.
- FSM states: IDLE, FLUSH, VECTOR, HANDLER, RETURN.
  - IDLE -> FLUSH on take: EPC <= `pc_next`, EXL <= 1, latch winning line = lowest-index set bit of IP & IM.
  - FLUSH (1 cycle): `flush`=1.
  - VECTOR (1 cycle): `pc_load`=1, `pc_target`=HANDLER_ADDR, `irq_ack`=latched one-hot. -> HANDLER.
  - HANDLER: wait; `eret`=1 -> RETURN.
  - RETURN (1 cycle): `pc_load`=1, `pc_target`=EPC, EXL <= 0. -> IDLE.
- `eret` outside HANDLER: ignored, no outputs asserted.
- Nested interrupts: none; EXL blocks take until RETURN completes.
- Simultaneous `mtc0` and hardware update on same edge: hardware wins for EPC (on take) and EXL (on take/RETURN); other written bits of Status still apply.
- `mtc0` to 12 setting EXL=0 while in HANDLER does not leave HANDLER.

## Timing
- Reset: state IDLE; Status, Cause, EPC = 0; `flush`, `pc_load`, `irq_ack` = 0; `pc_target` = 0; latched line cleared. Reset asserted mid-sequence aborts immediately to these values.
- `irq_in` rising at edge N is visible in IP after edge N+1; earliest take decision in cycle after N+1.
- Take at edge T: `flush` high in cycle T..T+1, `pc_load`/`irq_ack` high in cycle T+1..T+2, HANDLER from edge T+2.
- `eret` sampled at edge E in HANDLER: `pc_load` with EPC high in cycle E..E+1; IDLE from edge E+1; next take possible from the edge after that.
- All outputs except `mfc0_data` are registered-state-decoded (no combinational path from inputs).

## Test plan
- Reset then read: assert `rst` async mid-cycle -> `mfc0_data`=0 for addr 12/13/14, all strobes 0, state IDLE.
- Basic entry/exit: Status=32'h0000_0401 (IE, IM0), `irq_in`=6'b000001, `pc_next`=32'h0000_1234, `boundary`=1 -> `flush` 1 cycle, then `pc_load`=1 `pc_target`=32'h80 `irq_ack`=6'b000001, EPC=32'h1234, Status EXL=1; `eret` -> `pc_target`=32'h1234, EXL=0.
- Masking: IM=0 or IE=0 or `boundary`=0 with `irq_in` active -> no `flush`/`pc_load` for 20 cycles; Cause IP still shows 6'b000001.
- Priority: IM=6'b111111, `irq_in`=6'b101100 -> `irq_ack`=6'b000100.
- No nesting / stray eret: second irq during HANDLER -> no re-entry; `eret` in IDLE -> no `pc_load`.
- Write conflict: `mtc0` EPC=32'hDEAD_BEEF on take edge -> EPC=`pc_next`; `mtc0` to 13 -> Cause unchanged.
